// File: rtl/fft_pkg.sv
// Shared state encoding and default sizing for the FFT stage sequencer.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int FFT_ADDR_W = 10;
  localparam int FFT_N_CH   = 4;

  // Select width never collapses to zero bits, even for two channels.
  function automatic int sel_width(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chan_dec.sv
// Binary channel index to one-hot enable; all-zero when disabled or index out of range.
module chan_dec #(
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
) (
  input  logic             en,
  input  logic [SEL_W-1:0] idx,
  output logic [N_CH-1:0]  oh
);

  always_comb begin
    oh = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (en && (idx == SEL_W'(i))) oh[i] = 1'b1;
    end
  end

endmodule

// File: rtl/fft_stage_seq.sv
// Address/channel sequencer for one FFT stage: walks 0..len_m1 on one channel or
// sweeps channels sel_base..N_CH-1 back to back, with stall, done and err pulses.
module fft_stage_seq
  import fft_pkg::*;
#(
  parameter  int ADDR_W = FFT_ADDR_W,
  parameter  int N_CH   = FFT_N_CH,
  localparam int SEL_W  = sel_width(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel_base,
  input  logic [ADDR_W-1:0] len_m1,
  input  logic              stall,
  output logic              busy,
  output logic [N_CH-1:0]   ch_en,
  output logic [SEL_W-1:0]  ch_idx,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_vld,
  output logic              last,
  output logic              done,
  output logic              err
);

  localparam logic [SEL_W:0]   N_CH_L  = (SEL_W + 1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              vld_q, vld_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [N_CH-1:0]   ch_en_q, ch_en_d;
  logic [ADDR_W-1:0] addr_inc;

  assign addr_inc = addr_q + ADDR_W'(1);

  // addr_q always holds the most recently issued address; a stall simply
  // withholds the next advance, so resuming continues from addr_q + 1.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    ch_d    = ch_q;
    addr_d  = addr_q;
    vld_d   = 1'b0;
    last_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    busy_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ({1'b0, sel_base} < N_CH_L) begin
            state_d = ST_RUN;
            mode_d  = mode;
            len_d   = len_m1;
            ch_d    = sel_base;
            addr_d  = '0;
            vld_d   = 1'b1;
            last_d  = (len_m1 == '0);
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        busy_d = 1'b1;
        if (!stall) begin
          if (addr_q == len_q) begin
            if (mode_q && (ch_q < LAST_CH)) begin
              ch_d   = ch_q + SEL_W'(1);
              addr_d = '0;
              vld_d  = 1'b1;
              last_d = (len_q == '0);
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              ch_d    = '0;
              addr_d  = '0;
            end
          end else begin
            addr_d = addr_inc;
            vld_d  = 1'b1;
            last_d = (addr_inc == len_q);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  chan_dec #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_chan_dec (
    .en  (vld_d),
    .idx (ch_d),
    .oh  (ch_en_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      len_q   <= '0;
      ch_q    <= '0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ch_en_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      ch_q    <= ch_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      ch_en_q <= ch_en_d;
    end
  end

  assign busy     = busy_q;
  assign ch_en    = ch_en_q;
  assign ch_idx   = ch_q;
  assign addr     = addr_q;
  assign addr_vld = vld_q;
  assign last     = last_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_fft_stage_seq.sv
// Scoreboard bench for fft_stage_seq: a sequence model fills an expectation queue,
// a negedge monitor pops and compares every valid address and done pulse.
module tb_fft_stage_seq;

  localparam int AW = 4;
  localparam int NC = 4;

  typedef struct {
    int ch;
    int addr;
    bit last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, mode = 1'b0, stall = 1'b0;
  logic [1:0]    sel_base = '0;
  logic [AW-1:0] len_m1 = '0;
  logic          busy, addr_vld, last, done, err;
  logic [NC-1:0] ch_en;
  logic [1:0]    ch_idx;
  logic [AW-1:0] addr;

  logic          start3 = 1'b0, mode3 = 1'b0, stall3 = 1'b0;
  logic [1:0]    sel3 = '0;
  logic [AW-1:0] len3 = '0;
  logic          busy3, addr_vld3, last3, done3, err3;
  logic [2:0]    ch_en3;
  logic [1:0]    ch_idx3;
  logic [AW-1:0] addr3;

  int   n_chk = 0;
  int   n_pass = 0;
  int   done_cnt = 0;
  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  fft_stage_seq #(.ADDR_W(AW), .N_CH(NC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .sel_base(sel_base),
    .len_m1(len_m1), .stall(stall), .busy(busy), .ch_en(ch_en), .ch_idx(ch_idx),
    .addr(addr), .addr_vld(addr_vld), .last(last), .done(done), .err(err)
  );

  fft_stage_seq #(.ADDR_W(AW), .N_CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode3), .sel_base(sel3),
    .len_m1(len3), .stall(stall3), .busy(busy3), .ch_en(ch_en3), .ch_idx(ch_idx3),
    .addr(addr3), .addr_vld(addr_vld3), .last(last3), .done(done3), .err(err3)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference: every channel of the sequence visits addresses 0..len in order.
  task automatic model_push(input bit m, input int base, input int len);
    int hi;
    hi = m ? NC - 1 : base;
    for (int c = base; c <= hi; c++)
      for (int a = 0; a <= len; a++)
        q.push_back('{ch: c, addr: a, last: (a == len)});
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (addr_vld) begin
        if (q.size() == 0) chk("unexpected_vld", 1, 0);
        else begin
          mon_e = q.pop_front();
          chk("ch_idx", longint'(ch_idx), longint'(mon_e.ch));
          chk("addr", longint'(addr), longint'(mon_e.addr));
          chk("last", longint'(last), longint'(mon_e.last));
          chk("ch_en", longint'(ch_en), longint'(1 << mon_e.ch));
        end
      end else begin
        chk("ch_en_novld", longint'(ch_en), 0);
        chk("last_novld", longint'(last), 0);
      end
      if (done) begin
        chk("done_queue_empty", longint'(q.size()), 0);
        chk("done_busy", longint'(busy), 1);
        done_cnt++;
      end
    end
  end

  task automatic wait_idle(input string nm);
    int k;
    for (k = 0; k < 400; k++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    chk({nm, "_timeout"}, longint'(busy), 0);
  endtask

  task automatic do_seq(input bit m, input int base, input int len, input bit rnd);
    int d0;
    int k;
    d0 = done_cnt;
    model_push(m, base, len);
    mode = m; sel_base = 2'(base); len_m1 = AW'(len); start = 1'b1;
    @(posedge clk); #1;
    chk("first_vld", longint'(addr_vld), 1);
    chk("busy_run", longint'(busy), 1);
    start = 1'b0;
    for (k = 0; k < 400; k++) begin
      if (!busy) break;
      if (rnd) begin
        stall    = ($urandom_range(0, 2) == 0);
        start    = 1'($urandom_range(0, 1));
        mode     = 1'($urandom_range(0, 1));
        sel_base = 2'($urandom_range(0, 3));
        len_m1   = AW'($urandom_range(0, 15));
      end
      @(posedge clk); #1;
    end
    stall = 1'b0; start = 1'b0;
    chk("seq_timeout", longint'(busy), 0);
    chk("done_count", longint'(done_cnt - d0), 1);
    chk("queue_drained", longint'(q.size()), 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, longint'(busy), 0);
    chk({nm, "_ch_en"}, longint'(ch_en), 0);
    chk({nm, "_ch_idx"}, longint'(ch_idx), 0);
    chk({nm, "_addr"}, longint'(addr), 0);
    chk({nm, "_vld"}, longint'(addr_vld), 0);
    chk({nm, "_last"}, longint'(last), 0);
    chk({nm, "_done"}, longint'(done), 0);
    chk({nm, "_err"}, longint'(err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #12;
    chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    do_seq(1'b0, 2, 3, 1'b0);
    do_seq(1'b1, 1, 1, 1'b0);

    // Directed stall at address 1.
    model_push(1'b0, 0, 5);
    mode = 1'b0; sel_base = 2'd0; len_m1 = AW'(5); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    chk("pre_stall_addr", longint'(addr), 1);
    stall = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("stall_vld", longint'(addr_vld), 0);
      chk("stall_addr", longint'(addr), 1);
    end
    stall = 1'b0;
    @(posedge clk); #1;
    chk("resume_addr", longint'(addr), 2);
    chk("resume_vld", longint'(addr_vld), 1);
    wait_idle("stall");

    // Start pulsed mid-run with different settings must be ignored.
    model_push(1'b0, 1, 4);
    mode = 1'b0; sel_base = 2'd1; len_m1 = AW'(4); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("busy_start_addr", longint'(addr), 2);
    start = 1'b1; mode = 1'b1; sel_base = 2'd0; len_m1 = AW'(9);
    @(posedge clk); #1; start = 1'b0;
    wait_idle("busy_start");

    do_seq(1'b0, 3, 15, 1'b0);
    do_seq(1'b1, 0, 0, 1'b0);

    // Asynchronous reset in the middle of a sweep.
    model_push(1'b1, 0, 7);
    mode = 1'b1; sel_base = 2'd0; len_m1 = AW'(7); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("pre_rst_addr", longint'(addr), 2);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrun_reset");
    q.delete();
    @(negedge clk); rst_n = 1'b1;
    do_seq(1'b0, 3, 2, 1'b0);

    // Three-channel instance: out-of-range select, then a short sweep.
    sel3 = 2'd3; start3 = 1'b1;
    @(posedge clk); #1; start3 = 1'b0;
    chk("err3_pulse", longint'(err3), 1);
    chk("err3_busy", longint'(busy3), 0);
    chk("err3_vld", longint'(addr_vld3), 0);
    @(posedge clk); #1;
    chk("err3_clear", longint'(err3), 0);
    chk("err3_busy2", longint'(busy3), 0);
    mode3 = 1'b1; sel3 = 2'd1; len3 = AW'(1); start3 = 1'b1;
    @(posedge clk); #1; start3 = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (!busy3) break;
      if (addr_vld3) begin
        chk("d3_ch", longint'(ch_idx3), longint'(1 + n / 2));
        chk("d3_addr", longint'(addr3), longint'(n % 2));
        chk("d3_last", longint'(last3), longint'(n % 2));
        chk("d3_en", longint'(ch_en3), longint'(1 << (1 + n / 2)));
        n++;
      end
      @(posedge clk); #1;
    end
    chk("d3_count", longint'(n), 4);
    chk("d3_idle", longint'(busy3), 0);

    for (int s = 0; s < 25; s++)
      do_seq(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 7)), 1'b1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
